// File: rtl/vector_div_seq.sv
// Multi-lane sequential divider: restoring division, one quotient bit per cycle
// in every lane, followed by a sign/special-case fix-up cycle and a done pulse.
module vector_div_seq #(
   parameter int WIDTH = 8,
   parameter int LANES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [4:0]             FS,
   input  logic [LANES*WIDTH-1:0] S,
   input  logic [LANES*WIDTH-1:0] T,
   output logic [LANES*WIDTH-1:0] VY_lo,
   output logic [LANES*WIDTH-1:0] VY_hi,
   output logic [LANES-1:0]       div_by_zero,
   output logic                   busy,
   output logic                   done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [5:0]       LAST = 6'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   logic [1:0] state;
   logic [5:0] count;
   logic       accept;
   logic       signedOp;

   logic [WIDTH-1:0] quo      [LANES];
   logic [WIDTH-1:0] rem      [LANES];
   logic [WIDTH-1:0] dvs      [LANES];
   logic [WIDTH-1:0] dividend [LANES];
   logic [WIDTH:0]   shifted  [LANES];
   logic [LANES-1:0] fits;
   logic [LANES-1:0] qneg;
   logic [LANES-1:0] rneg;
   logic [LANES-1:0] zero;

   // Two's-complement magnitude; the most negative value maps to 2**(WIDTH-1) unsigned
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sg);
      return (sg && x[WIDTH-1]) ? (~x + ONE) : x;
   endfunction

   assign accept   = (state == IDLE) && start && ((FS == 5'h03) || (FS == 5'h04));
   assign signedOp = (FS == 5'h04);
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

   always_comb begin
      fits = '0;
      for (int i = 0; i < LANES; i++) begin
         shifted[i] = {rem[i], quo[i][WIDTH-1]};
         fits[i]    = (shifted[i] >= {1'b0, dvs[i]});
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
      end else begin
         case (state)
            IDLE: begin
               count <= '0;
               if (accept) state <= CALC;
            end
            CALC: begin
               count <= count + 6'd1;
               if (count == LAST) state <= FIX;
            end
            FIX:     state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

   // The quotient register starts holding the dividend magnitude and shifts it out MSB first
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         VY_lo       <= '0;
         VY_hi       <= '0;
         div_by_zero <= '0;
         qneg        <= '0;
         rneg        <= '0;
         zero        <= '0;
         for (int i = 0; i < LANES; i++) begin
            quo[i]      <= '0;
            rem[i]      <= '0;
            dvs[i]      <= '0;
            dividend[i] <= '0;
         end
      end else if (accept) begin
         for (int i = 0; i < LANES; i++) begin
            quo[i]      <= magnitude(S[i*WIDTH +: WIDTH], signedOp);
            dvs[i]      <= magnitude(T[i*WIDTH +: WIDTH], signedOp);
            rem[i]      <= '0;
            dividend[i] <= S[i*WIDTH +: WIDTH];
            zero[i]     <= (T[i*WIDTH +: WIDTH] == '0);
            qneg[i]     <= signedOp && (S[i*WIDTH+WIDTH-1] ^ T[i*WIDTH+WIDTH-1]);
            rneg[i]     <= signedOp && S[i*WIDTH+WIDTH-1];
         end
      end else if (state == CALC) begin
         for (int i = 0; i < LANES; i++) begin
            quo[i] <= {quo[i][WIDTH-2:0], fits[i]};
            rem[i] <= fits[i] ? (shifted[i][WIDTH-1:0] - dvs[i]) : shifted[i][WIDTH-1:0];
         end
      end else if (state == FIX) begin
         // Negating the magnitude quotient 2**(WIDTH-1) wraps back to the most negative value
         for (int i = 0; i < LANES; i++) begin
            if (zero[i]) begin
               VY_lo[i*WIDTH +: WIDTH] <= '1;
               VY_hi[i*WIDTH +: WIDTH] <= dividend[i];
            end else begin
               VY_lo[i*WIDTH +: WIDTH] <= qneg[i] ? (~quo[i] + ONE) : quo[i];
               VY_hi[i*WIDTH +: WIDTH] <= rneg[i] ? (~rem[i] + ONE) : rem[i];
            end
         end
         div_by_zero <= zero;
      end
   end

endmodule

// File: tb/tb_vector_div_seq.sv
// Self-checking bench for vector_div_seq: directed cases, protocol corner cases
// and randomized operations compared against an arithmetic reference model.
module tb_vector_div_seq;

   localparam int WIDTH = 8;
   localparam int LANES = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [4:0]  FS;
   logic [31:0] S, T;
   logic [31:0] VY_lo, VY_hi;
   logic [3:0]  div_by_zero;
   logic        busy, done;

   int checks = 0;
   int passes = 0;

   logic [31:0] lastLo = '0;
   logic [31:0] lastHi = '0;
   logic [3:0]  lastZ  = '0;

   vector_div_seq #(.WIDTH(WIDTH), .LANES(LANES)) dut (
      .clk(clk), .reset(reset), .start(start), .FS(FS), .S(S), .T(T),
      .VY_lo(VY_lo), .VY_hi(VY_hi), .div_by_zero(div_by_zero),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Every comparison in the bench funnels through here
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs === exp) passes++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] pack4(input logic [7:0] a0, input logic [7:0] a1,
                                         input logic [7:0] a2, input logic [7:0] a3);
      return {a3, a2, a1, a0};
   endfunction

   // Reference: plain integer division (truncating) with the documented special cases
   task automatic model(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t,
                        output logic [31:0] lo, output logic [31:0] hi, output logic [3:0] z);
      logic [7:0] a, b;
      int sa, sb, q, r;
      lo = '0; hi = '0; z = '0;
      for (int i = 0; i < LANES; i++) begin
         a = s[i*8 +: 8];
         b = t[i*8 +: 8];
         if (b == 8'd0) begin
            q = 255; r = int'(a); z[i] = 1'b1;
         end else if (fs == 5'h04) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (sa == -128 && sb == -1) begin
               q = -128; r = 0;
            end else begin
               q = sa / sb; r = sa % sb;
            end
         end else begin
            q = int'(a) / int'(b); r = int'(a) % int'(b);
         end
         lo[i*8 +: 8] = q[7:0];
         hi[i*8 +: 8] = r[7:0];
      end
   endtask

   task automatic watch(input int n, output int doneCount, output int busyCount);
      doneCount = 0; busyCount = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (done) doneCount++;
         if (busy) busyCount++;
      end
   endtask

   // disturb bit0: extra start (with new data) mid-CALC; bit1: extra start during DONE
   task automatic applyStimulus(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t,
                                input int disturb, input logic [31:0] eLo, input logic [31:0] eHi,
                                input logic [3:0] eZ);
      int lat, dc, bc;
      FS = fs; S = s; T = t; start = 1'b1;
      @(negedge clk);
      start = 1'b0; FS = 5'h00; S = $urandom; T = $urandom;
      lat = 1;
      while (!done && lat < 40) begin
         if (disturb[0] && lat == 4) begin
            start = 1'b1; FS = 5'h04;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      checkOutput("latency", lat, 10);
      checkOutput("quotient", VY_lo, eLo);
      checkOutput("remainder", VY_hi, eHi);
      checkOutput("divByZero", div_by_zero, eZ);
      checkOutput("busyInDone", busy, 1);
      lastLo = eLo; lastHi = eHi; lastZ = eZ;
      if (disturb[1]) begin
         start = 1'b1; FS = 5'h03;
      end
      @(negedge clk);
      start = 1'b0;
      checkOutput("donePulseWidth", done, 0);
      checkOutput("idleAfterDone", busy, 0);
      checkOutput("holdQuotient", VY_lo, eLo);
      if (disturb != 0) begin
         watch(12, dc, bc);
         checkOutput("noExtraDone", dc, 0);
         checkOutput("noExtraBusy", bc, 0);
         checkOutput("holdAfterIgnored", VY_lo, eLo);
      end
   endtask

   initial begin
      logic [31:0] s, t, eLo, eHi;
      logic [3:0]  eZ;
      logic [4:0]  fs;
      int dc, bc, pick;

      reset = 1'b1; start = 1'b0; FS = 5'h00; S = '0; T = '0;
      repeat (3) @(negedge clk);
      checkOutput("resetLo", VY_lo, 0);
      checkOutput("resetHi", VY_hi, 0);
      checkOutput("resetDbz", div_by_zero, 0);
      checkOutput("resetBusy", busy, 0);
      checkOutput("resetDone", done, 0);
      reset = 1'b0;
      @(negedge clk);

      applyStimulus(5'h03, pack4(8'd200, 8'd7, 8'd255, 8'd0), pack4(8'd7, 8'd7, 8'd1, 8'd5), 0,
                    pack4(8'd28, 8'd1, 8'd255, 8'd0), pack4(8'd4, 8'd0, 8'd0, 8'd0), 4'b0000);
      applyStimulus(5'h04, pack4(8'hF9, 8'd7, 8'h80, 8'h80), pack4(8'd2, 8'hFE, 8'hFF, 8'd3), 1,
                    pack4(8'hFD, 8'hFD, 8'h80, 8'hD6), pack4(8'hFF, 8'd1, 8'd0, 8'hFE), 4'b0000);
      applyStimulus(5'h03, pack4(8'd9, 8'd0, 8'd1, 8'd2), pack4(8'd0, 8'd3, 8'd0, 8'd1), 2,
                    pack4(8'hFF, 8'd0, 8'hFF, 8'd2), pack4(8'd9, 8'd0, 8'd1, 8'd0), 4'b0101);

      // Unsupported function code in IDLE
      FS = 5'h05; S = $urandom; T = $urandom; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      watch(12, dc, bc);
      checkOutput("badFsDone", dc, 0);
      checkOutput("badFsBusy", bc, 0);
      checkOutput("badFsLo", VY_lo, lastLo);
      checkOutput("badFsHi", VY_hi, lastHi);
      checkOutput("badFsDbz", div_by_zero, lastZ);

      // Reset in the fourth CALC cycle
      FS = 5'h03; S = pack4(8'd50, 8'd60, 8'd70, 8'd80); T = pack4(8'd3, 8'd4, 8'd5, 8'd6); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("abortLo", VY_lo, 0);
      checkOutput("abortHi", VY_hi, 0);
      checkOutput("abortDbz", div_by_zero, 0);
      checkOutput("abortBusy", busy, 0);
      checkOutput("abortDone", done, 0);
      @(negedge clk);
      reset = 1'b0;
      watch(20, dc, bc);
      checkOutput("abortNoDone", dc, 0);
      checkOutput("abortNoBusy", bc, 0);

      applyStimulus(5'h03, pack4(8'd200, 8'd7, 8'd255, 8'd0), pack4(8'd7, 8'd7, 8'd1, 8'd5), 0,
                    pack4(8'd28, 8'd1, 8'd255, 8'd0), pack4(8'd4, 8'd0, 8'd0, 8'd0), 4'b0000);

      // Randomized back-to-back operations with occasional zero divisors and overflow lanes
      for (int n = 0; n < 40; n++) begin
         fs = ($urandom_range(0, 1) == 0) ? 5'h03 : 5'h04;
         s = $urandom;
         t = $urandom;
         for (int i = 0; i < LANES; i++) begin
            pick = $urandom_range(0, 9);
            if (pick == 0) t[i*8 +: 8] = 8'h00;
            else if (pick == 1) begin
               s[i*8 +: 8] = 8'h80; t[i*8 +: 8] = 8'hFF;
            end else if (pick == 2) t[i*8 +: 8] = 8'(1 + $urandom_range(0, 3));
         end
         model(fs, s, t, eLo, eHi, eZ);
         applyStimulus(fs, s, t, (n % 8 == 7) ? 3 : 0, eLo, eHi, eZ);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/vector_div_seq.md
VECTOR_DIV_SEQ -- requirements
Module: vector_div_seq

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the per-lane operand and result width in bits (legal range 4..32).
REQ-002 Parameter LANES, default 4, SHALL set the number of independent divide lanes (legal range 1..8).
REQ-003 Lane i SHALL occupy bits [i*WIDTH +: WIDTH] of every packed bus.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 start  input  1  SHALL request a new operation; it is sampled only in IDLE.
REQ-007 FS  input  5  SHALL select the function: 5'h03 unsigned divide, 5'h04 signed divide, any other value no operation.
REQ-008 S  input  LANES*WIDTH  SHALL carry the packed dividends.
REQ-009 T  input  LANES*WIDTH  SHALL carry the packed divisors.
REQ-010 VY_lo  output  LANES*WIDTH  SHALL carry the packed quotients (registered).
REQ-011 VY_hi  output  LANES*WIDTH  SHALL carry the packed remainders (registered).
REQ-012 div_by_zero  output  LANES  SHALL flag each lane whose divisor was zero (registered).
REQ-013 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-014 done  output  1  SHALL be a one-cycle pulse marking valid results.

Function
REQ-015 The state machine SHALL have four states: IDLE, CALC, FIX and DONE.
REQ-016 Transitions:
- IDLE->CALC when start=1 and FS is 5'h03 or 5'h04.
- CALC->FIX after exactly WIDTH CALC cycles.
- FIX->DONE unconditionally.
- DONE->IDLE unconditionally.
REQ-017 At the IDLE->CALC edge the block SHALL capture S, T and the mode; later changes to S, T or FS SHALL NOT affect the operation in flight.
REQ-018 In signed mode each lane SHALL divide operand magnitudes and record the quotient sign (S xor T) and the remainder sign (sign of S).
REQ-019 CALC SHALL perform restoring division, one quotient bit per cycle per lane, MSB first, all lanes in parallel.
REQ-020 FIX SHALL apply sign correction and the special-case rules below, then load VY_lo, VY_hi and div_by_zero.
REQ-021 done SHALL be 1 only in DONE, i.e. WIDTH+2 cycles after the cycle in which start was accepted.
REQ-022 Outputs SHALL hold their values from the load until the next FIX.
REQ-023 Quotients SHALL truncate toward zero, and every remainder SHALL satisfy S = Q*T + R with |R| < |T|.
REQ-024 A lane with T=0 SHALL return quotient = all ones, remainder = S, and div_by_zero bit = 1, in both modes; other lanes SHALL be unaffected.
REQ-025 A signed lane with S = most negative and T = -1 SHALL return quotient = S and remainder = 0, with div_by_zero bit = 0.
REQ-026 start while busy=1, including during DONE, SHALL be ignored and SHALL NOT be queued.
REQ-027 start=1 in IDLE with an unsupported FS SHALL leave the block in IDLE with outputs unchanged.
REQ-028 Back-to-back operations SHALL be possible: start accepted in the cycle after done yields the next done WIDTH+2 cycles later.

Reset
REQ-029 While reset=1, regardless of clock: state = IDLE; VY_lo, VY_hi, div_by_zero, busy and done = 0.
REQ-030 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow the deassertion of reset.
REQ-031 The first start after reset deassertion SHALL be accepted normally.

Verification (WIDTH=8, LANES=4)
REQ-032 Unsigned: FS=03, lanes S={200,7,255,0}, T={7,7,1,5} -> done at cycle 10; VY_lo={28,1,255,0}; VY_hi={4,0,0,0}; div_by_zero=0.
REQ-033 Signed: FS=04, S={-7,7,-128,-128}, T={2,-2,-1,3} -> VY_lo={-3,-3,-128,-42}; VY_hi={-1,1,0,-2}.
REQ-034 Divide by zero: FS=03, S={9,0,1,2}, T={0,3,0,1} -> VY_lo={FF,0,FF,2}; VY_hi={9,0,1,0}; div_by_zero=4'b0101.
REQ-035 start pulsed during CALC, and FS=05 with start in IDLE -> no extra done; outputs and busy unchanged by either.
REQ-036 reset pulsed at CALC cycle 4 -> outputs 0 immediately; no done pulse; the next start completes correctly.
